conv_ddr_packer: RTL
====================

Name: conv_ddr_packer

Overview:
- Sits directly downstream of the convolution output, on the 144-bit Conv_data_out / Conv_data_valid_out stream (18 channels × 8 bit).
- Packs that stream into 256-bit DDR write words for the DDR write path.
- The lcm of 144 and 256 is 2304, so 16 input beats always produce exactly 9 output words.
- Provides valid/ready output handshake, input backpressure, explicit flush with zero padding, and a sticky overflow flag.

Parameters:
- IN_WIDTH, 144, input beat width in bits.
- OUT_WIDTH, 256, DDR word width in bits.
- ACC_WIDTH, 400, accumulator capacity in bits; must be ≥ OUT_WIDTH+IN_WIDTH-1.
- CNT_WIDTH, 9, width of the accumulator fill counter; must hold ACC_WIDTH.

Ports:
- clk  input  1  single clock; all logic is in this domain.
- rst  input  1  asynchronous, active-high reset.
- conv_data_in  input  144  packed channel bytes; channel 0 in bits [7:0].
- conv_valid_in  input  1  input beat valid.
- conv_ready_out  output  1  packer can accept a beat this cycle.
- flush  input  1  one-cycle pulse that drains and zero-pads residual bits.
- ddr_data_out  output  256  packed word.
- ddr_valid_out  output  1  ddr_data_out is valid.
- ddr_ready_in  input  1  DDR side accepts the word.
- ddr_last_out  output  1  qualifies the final word of a flush.
- flush_done  output  1  one-cycle pulse when a flush completes.
- ovf  output  1  sticky; set when a beat arrives while conv_ready_out is 0.

Behaviour:
- Reset values (asynchronous): acc=0, cnt=0, ddr_data_out=0, ddr_valid_out=0, ddr_last_out=0, flush_done=0, ovf=0, state=RUN.
- Packing order is LSB-first. Each accepted beat is written at acc[cnt +: 144] after any same-cycle emit shift, then cnt += 144.
- Example: word0 = {beat1[111:0], beat0}; word1[31:0] = beat1[143:112].
- emit = (cnt ≥ 256 or flush padding condition) && (!ddr_valid_out || ddr_ready_in).
- On emit:
  - ddr_data_out <= acc[255:0];
  - acc >>= 256, with zero fill;
  - cnt -= 256, saturating to 0 when padding;
  - ddr_valid_out <= 1.
- When ddr_valid_out && ddr_ready_in && !emit, ddr_valid_out <= 0.
- ddr_data_out and ddr_last_out are held stable while ddr_valid_out=1 and ddr_ready_in=0.
- conv_ready_out = (state==RUN) && (cnt < 256 || emit). This is combinational from ddr_ready_in by design.
- Accept = conv_valid_in && conv_ready_out. Emit and accept in the same cycle are both applied.
- Latency: a word is registered the cycle after cnt reaches ≥256, i.e. one clk after the completing beat is accepted.
- Overflow: conv_valid_in=1 while conv_ready_out=0 sets ovf=1 and drops the beat. ovf clears only on rst.
- State machine:
  - RUN: flush=1 → FLUSH. flush is ignored while already in FLUSH.
  - FLUSH: no beats accepted. Emit full words while cnt ≥ 256. When 0 < cnt < 256, emit one zero-padded word.
  - The emit that leaves cnt=0 sets ddr_last_out=1 with that word.
  - When cnt=0 and the last word is accepted (or no word was pending at flush entry), pulse flush_done and return to RUN.
  - flush with cnt=0 and nothing pending → flush_done the next cycle; no word and no last is produced.
- ddr_last_out is cleared when its word is accepted.
- A flush pulse in the same cycle as an accepted beat: the beat is accepted first, then the FLUSH state is entered.
- Mid-operation rst clears all state immediately. A partially transferred word is lost.

Optional Feature:
- Macro: CONV_DDR_PACKER_STATS_EN.
- When defined:
  - Adds output word_cnt [31:0], incremented on every accepted DDR word (ddr_valid_out && ddr_ready_in).
  - Adds output beat_cnt [31:0], incremented on every accepted input beat.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- 16 consecutive beats, beat k = {18{k[7:0]}}, ddr_ready_in=1 → exactly 9 words. word0[143:0]=beat0, word0[255:144]=beat1[111:0]; word8 ends with beat15; cnt=0 afterward; no last.
- 1 beat of 0xFF.. then flush → 1 word: [143:0]=all ones, [255:144]=0, ddr_last_out=1. flush_done pulses 1 cycle after acceptance.
- Continuous input with ddr_ready_in=0 for 6 cycles:
  - conv_ready_out drops once cnt ≥ 256.
  - ddr_data_out is held stable while stalled.
  - After release, the word sequence matches the golden model; ovf=0.
- conv_valid_in held at 1 while conv_ready_out=0 → ovf=1 and stays 1. The dropped beat is absent from output, and subsequent packing matches the model skipping it.
- Flush with cnt=0 → flush_done next cycle, no DDR word. Flush with cnt=288 → two words, the second padded with zeros in [255:32] and last=1.
- rst asserted mid-stream with ddr_valid_out=1 → all outputs 0 immediately. The next 16 beats produce 9 words aligned from beat0.

Source files
------------

// File: rtl/conv_ddr_packer.sv
// Packs the 144-bit convolution output stream LSB-first into 256-bit DDR write words,
// with output backpressure, zero-padded flush and a sticky overflow flag.
// Optional build macro CONV_DDR_PACKER_STATS_EN adds word_cnt/beat_cnt statistics outputs.
module conv_ddr_packer #(
  parameter int IN_WIDTH  = 144,
  parameter int OUT_WIDTH = 256,
  parameter int ACC_WIDTH = 400,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  conv_data_in,
  input  logic                 conv_valid_in,
  output logic                 conv_ready_out,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] ddr_data_out,
  output logic                 ddr_valid_out,
  input  logic                 ddr_ready_in,
  output logic                 ddr_last_out,
  output logic                 flush_done,
  output logic                 ovf
`ifdef CONV_DDR_PACKER_STATS_EN
  ,
  output logic [31:0]          word_cnt,
  output logic [31:0]          beat_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] OUT_W_C = CNT_WIDTH'(OUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] IN_W_C  = CNT_WIDTH'(IN_WIDTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc, acc_shift, acc_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_shift, cnt_next;
  logic                   full, pad, out_free, emit, accept;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    full           = (cnt >= OUT_W_C);
    pad            = (state == FLUSH) && (cnt != '0) && !full;
    out_free       = !ddr_valid_out || ddr_ready_in;
    emit           = (full || pad) && out_free;
    conv_ready_out = (state == RUN) && (!full || emit);
    accept         = conv_valid_in && conv_ready_out;

    acc_shift = emit ? (acc >> OUT_WIDTH) : acc;
    cnt_shift = cnt;
    if (emit) cnt_shift = full ? (cnt - OUT_W_C) : '0;

    // A beat lands above whatever survives this cycle's emit shift.
    acc_next = acc_shift;
    cnt_next = cnt_shift;
    if (accept) begin
      acc_next = acc_shift | (ACC_WIDTH'(conv_data_in) << cnt_shift);
      cnt_next = cnt_shift + IN_W_C;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      acc           <= '0;
      cnt           <= '0;
      ddr_data_out  <= '0;
      ddr_valid_out <= 1'b0;
      ddr_last_out  <= 1'b0;
      flush_done    <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      acc        <= acc_next;
      cnt        <= cnt_next;
      flush_done <= 1'b0;

      if (emit) begin
        ddr_data_out  <= acc[OUT_WIDTH-1:0];
        ddr_valid_out <= 1'b1;
        ddr_last_out  <= (state == FLUSH) && (cnt_shift == '0);
      end else if (ddr_valid_out && ddr_ready_in) begin
        ddr_valid_out <= 1'b0;
        ddr_last_out  <= 1'b0;
      end

      if (conv_valid_in && !conv_ready_out) ovf <= 1'b1;

      case (state)
        RUN:   if (flush) state <= FLUSH;
        // Done once the accumulator is empty and no word is still waiting for DDR.
        FLUSH: if (cnt == '0 && out_free) begin
          flush_done <= 1'b1;
          state      <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef CONV_DDR_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (ddr_valid_out && ddr_ready_in) word_cnt <= word_cnt + 32'd1;
      if (accept)                        beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule
